keypad_calc_core: RTL

KEYPAD_CALC_CORE -- requirements
Module: keypad_calc_core

---
 rtl/keypad_calc_core.sv | 397 +++++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_calc_core.sv
// keypad_calc_core
//   Four-function keypad calculator core. Decoded key presses build two
//   decimal operands A and B; ADD completes in one execute cycle, MUL runs
//   a W-cycle shift-add and DIV a W-cycle restoring divide. A completed
//   result may be chained into the next operation as the new A.
//
// Ports
//   clk           : system clock, rising edge
//   rst           : asynchronous active-low reset
//   key_valid     : one-cycle strobe qualifying key_value
//   key_value     : 0-9 digit, A add, B mul, C div, D clear, E equals, F ignored
//   display_value : value for the BCD/display path (2W bits)
//   result        : result of the last completed operation (2W bits)
//   remainder     : remainder of the last completed division (W bits)
//   busy          : high while an operation executes
//   result_valid  : high while a completed result is presented
//   err_ovf       : sticky entry overflow / chain truncation flag
//   err_div0      : sticky division-by-zero flag
//
// All outputs come straight from flops; their next values are derived from
// the state being entered so they always agree with the current state.
module keypad_calc_core #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  input  logic [3:0]     key_value,
  output logic [2*W-1:0] display_value,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           busy,
  output logic           result_valid,
  output logic           err_ovf,
  output logic           err_div0
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_MUL = 4'hB;
  localparam logic [3:0] KEY_DIV = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;

  localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
  localparam logic [2*W-1:0] ZERO_2W  = {(2*W){1'b0}};
  localparam logic [2*W-1:0] ONES_2W  = {(2*W){1'b1}};
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_MUL = 2'd1,
    OP_DIV = 2'd2
  } op_t;

  // v*10 + d evaluated at W+4 bits so the overflow test never wraps:
  // (2^W-1)*10 + 9 < 2^(W+4).
  function automatic logic [W+3:0] digit_acc(input logic [W-1:0] v,
                                             input logic [3:0]   d);
    logic [W+3:0] ext;
    ext = {4'b0000, v};
    return (ext << 3) + (ext << 1) + {{W{1'b0}}, d};
  endfunction

  // Registered state
  state_t         state_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  op_t            op_r;
  logic [2*W-1:0] result_r;
  logic [W-1:0]   rem_r;
  logic           show_rem_r;
  logic           err_ovf_r;
  logic           err_div0_r;
  logic [CW-1:0]  cnt_r;
  logic [2*W-1:0] mul_acc_r;
  logic [2*W-1:0] mul_a_r;
  logic [W-1:0]   mul_b_r;
  logic [W-1:0]   div_rem_r;
  logic [W-1:0]   div_q_r;
  logic           busy_r;
  logic           valid_r;
  logic [2*W-1:0] disp_r;

  // Next values
  state_t         state_nxt_s;
  logic [W-1:0]   a_nxt_s;
  logic [W-1:0]   b_nxt_s;
  op_t            op_nxt_s;
  logic [2*W-1:0] result_nxt_s;
  logic [W-1:0]   rem_nxt_s;
  logic           show_nxt_s;
  logic           ovf_nxt_s;
  logic           div0_nxt_s;
  logic [CW-1:0]  cnt_nxt_s;
  logic [2*W-1:0] mul_acc_nxt_s;
  logic [2*W-1:0] mul_a_nxt_s;
  logic [W-1:0]   mul_b_nxt_s;
  logic [W-1:0]   div_rem_nxt_s;
  logic [W-1:0]   div_q_nxt_s;
  logic [2*W-1:0] disp_nxt_s;

  // Key decode and datapath helpers
  logic           is_digit_s;
  logic           is_op_s;
  logic           is_eq_s;
  logic           is_clr_s;
  op_t            key_op_s;
  logic [W+3:0]   a_acc_s;
  logic [W+3:0]   b_acc_s;
  logic           a_fit_s;
  logic           b_fit_s;
  logic [2*W-1:0] mul_sum_s;
  logic [W:0]     div_trial_s;
  logic           div_ge_s;
  logic [W-1:0]   div_diff_s;
  logic [W-1:0]   div_rem_step_s;
  logic [W-1:0]   div_q_step_s;
  logic           last_s;

  assign is_digit_s = key_valid & (key_value <= 4'd9);
  assign is_op_s    = key_valid & ((key_value == KEY_ADD) |
                                   (key_value == KEY_MUL) |
                                   (key_value == KEY_DIV));
  assign is_eq_s    = key_valid & (key_value == KEY_EQ);
  assign is_clr_s   = key_valid & (key_value == KEY_CLR);

  assign a_acc_s = digit_acc(a_r, key_value);
  assign b_acc_s = digit_acc(b_r, key_value);
  assign a_fit_s = (a_acc_s[W+3:W] == 4'b0000);
  assign b_fit_s = (b_acc_s[W+3:W] == 4'b0000);

  // Shift-add multiply: mul_a_r holds A shifted left by the step count,
  // mul_b_r holds B shifted right so bit 0 is the current multiplier bit.
  assign mul_sum_s = mul_acc_r + (mul_b_r[0] ? mul_a_r : ZERO_2W);

  // Restoring divide: partial remainder shifted left with the next dividend
  // bit; when the trial is >= B the difference fits in W bits because it is
  // below B, so the W-bit subtraction is exact.
  assign div_trial_s    = {div_rem_r, div_q_r[W-1]};
  assign div_ge_s       = (div_trial_s >= {1'b0, b_r});
  assign div_diff_s     = div_trial_s[W-1:0] - b_r;
  assign div_rem_step_s = div_ge_s ? div_diff_s : div_trial_s[W-1:0];
  assign div_q_step_s   = {div_q_r[W-2:0], div_ge_s};

  assign last_s = (cnt_r == CNT_LAST);

  // Operator key to operation code
  always_comb begin
    key_op_s = OP_ADD;
    case (key_value)
      KEY_MUL: key_op_s = OP_MUL;
      KEY_DIV: key_op_s = OP_DIV;
      default: key_op_s = OP_ADD;
    endcase
  end

  // Next-state and next-datapath decode for the calculator FSM
  always_comb begin
    state_nxt_s   = state_r;
    a_nxt_s       = a_r;
    b_nxt_s       = b_r;
    op_nxt_s      = op_r;
    result_nxt_s  = result_r;
    rem_nxt_s     = rem_r;
    show_nxt_s    = show_rem_r;
    ovf_nxt_s     = err_ovf_r;
    div0_nxt_s    = err_div0_r;
    cnt_nxt_s     = cnt_r;
    mul_acc_nxt_s = mul_acc_r;
    mul_a_nxt_s   = mul_a_r;
    mul_b_nxt_s   = mul_b_r;
    div_rem_nxt_s = div_rem_r;
    div_q_nxt_s   = div_q_r;

    if (is_clr_s) begin
      // CLEAR wins in every state, including mid-execute
      state_nxt_s  = ENTER_A;
      a_nxt_s      = ZERO_W;
      b_nxt_s      = ZERO_W;
      op_nxt_s     = OP_ADD;
      result_nxt_s = ZERO_2W;
      rem_nxt_s    = ZERO_W;
      show_nxt_s   = 1'b0;
      ovf_nxt_s    = 1'b0;
      div0_nxt_s   = 1'b0;
      cnt_nxt_s    = CNT_ZERO;
    end else begin
      case (state_r)
        ENTER_A: begin
          if (is_digit_s) begin
            if (a_fit_s) begin
              a_nxt_s = a_acc_s[W-1:0];
            end else begin
              ovf_nxt_s = 1'b1;
            end
          end else if (is_op_s) begin
            op_nxt_s    = key_op_s;
            b_nxt_s     = ZERO_W;
            state_nxt_s = ENTER_B;
          end else begin
            state_nxt_s = ENTER_A;
          end
        end

        ENTER_B: begin
          if (is_digit_s) begin
            if (b_fit_s) begin
              b_nxt_s = b_acc_s[W-1:0];
            end else begin
              ovf_nxt_s = 1'b1;
            end
          end else if (is_op_s) begin
            op_nxt_s = key_op_s;
          end else if (is_eq_s) begin
            // Load the iterative engines; result/remainder stay untouched
            // until the operation completes.
            state_nxt_s   = EXEC;
            show_nxt_s    = 1'b0;
            cnt_nxt_s     = CNT_ZERO;
            mul_acc_nxt_s = ZERO_2W;
            mul_a_nxt_s   = (2*W)'(a_r);
            mul_b_nxt_s   = b_r;
            div_rem_nxt_s = ZERO_W;
            div_q_nxt_s   = a_r;
          end else begin
            state_nxt_s = ENTER_B;
          end
        end

        EXEC: begin
          case (op_r)
            OP_ADD: begin
              result_nxt_s = (2*W)'(a_r) + (2*W)'(b_r);
              state_nxt_s  = DONE;
            end
            OP_MUL: begin
              mul_acc_nxt_s = mul_sum_s;
              mul_a_nxt_s   = {mul_a_r[2*W-2:0], 1'b0};
              mul_b_nxt_s   = {1'b0, mul_b_r[W-1:1]};
              cnt_nxt_s     = cnt_r + CNT_ONE;
              if (last_s) begin
                result_nxt_s = mul_sum_s;
                state_nxt_s  = DONE;
              end else begin
                state_nxt_s = EXEC;
              end
            end
            OP_DIV: begin
              if (b_r == ZERO_W) begin
                result_nxt_s = ONES_2W;
                rem_nxt_s    = a_r;
                div0_nxt_s   = 1'b1;
                state_nxt_s  = DONE;
              end else begin
                div_rem_nxt_s = div_rem_step_s;
                div_q_nxt_s   = div_q_step_s;
                cnt_nxt_s     = cnt_r + CNT_ONE;
                if (last_s) begin
                  result_nxt_s = (2*W)'(div_q_step_s);
                  rem_nxt_s    = div_rem_step_s;
                  state_nxt_s  = DONE;
                end else begin
                  state_nxt_s = EXEC;
                end
              end
            end
            default: begin
              state_nxt_s = ENTER_A;
            end
          endcase
        end

        DONE: begin
          if (is_digit_s) begin
            // Fresh calculation
            a_nxt_s     = W'(key_value);
            b_nxt_s     = ZERO_W;
            ovf_nxt_s   = 1'b0;
            div0_nxt_s  = 1'b0;
            state_nxt_s = ENTER_A;
          end else if (is_op_s) begin
            // Chain: low half of the result becomes A, lost high bits flag
            a_nxt_s     = result_r[W-1:0];
            op_nxt_s    = key_op_s;
            b_nxt_s     = ZERO_W;
            state_nxt_s = ENTER_B;
            if (result_r[2*W-1:W] != ZERO_W) begin
              ovf_nxt_s = 1'b1;
            end else begin
              ovf_nxt_s = err_ovf_r;
            end
          end else if (is_eq_s) begin
            if (op_r == OP_DIV) begin
              show_nxt_s = ~show_rem_r;
            end else begin
              show_nxt_s = show_rem_r;
            end
          end else begin
            state_nxt_s = DONE;
          end
        end

        default: begin
          state_nxt_s = ENTER_A;
        end
      endcase
    end
  end

  // Display source follows the state being entered
  always_comb begin
    disp_nxt_s = disp_r;
    case (state_nxt_s)
      ENTER_A: disp_nxt_s = (2*W)'(a_nxt_s);
      ENTER_B: disp_nxt_s = (2*W)'(b_nxt_s);
      EXEC:    disp_nxt_s = disp_r;
      DONE: begin
        if (show_nxt_s) begin
          disp_nxt_s = (2*W)'(rem_nxt_s);
        end else begin
          disp_nxt_s = result_nxt_s;
        end
      end
      default: disp_nxt_s = ZERO_2W;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ENTER_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, result, engine and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r        <= ZERO_W;
      b_r        <= ZERO_W;
      op_r       <= OP_ADD;
      result_r   <= ZERO_2W;
      rem_r      <= ZERO_W;
      show_rem_r <= 1'b0;
      err_ovf_r  <= 1'b0;
      err_div0_r <= 1'b0;
      cnt_r      <= CNT_ZERO;
      mul_acc_r  <= ZERO_2W;
      mul_a_r    <= ZERO_2W;
      mul_b_r    <= ZERO_W;
      div_rem_r  <= ZERO_W;
      div_q_r    <= ZERO_W;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      disp_r     <= ZERO_2W;
    end else begin
      a_r        <= a_nxt_s;
      b_r        <= b_nxt_s;
      op_r       <= op_nxt_s;
      result_r   <= result_nxt_s;
      rem_r      <= rem_nxt_s;
      show_rem_r <= show_nxt_s;
      err_ovf_r  <= ovf_nxt_s;
      err_div0_r <= div0_nxt_s;
      cnt_r      <= cnt_nxt_s;
      mul_acc_r  <= mul_acc_nxt_s;
      mul_a_r    <= mul_a_nxt_s;
      mul_b_r    <= mul_b_nxt_s;
      div_rem_r  <= div_rem_nxt_s;
      div_q_r    <= div_q_nxt_s;
      busy_r     <= (state_nxt_s == EXEC);
      valid_r    <= (state_nxt_s == DONE);
      disp_r     <= disp_nxt_s;
    end
  end

  assign display_value = disp_r;
  assign result        = result_r;
  assign remainder     = rem_r;
  assign busy          = busy_r;
  assign result_valid  = valid_r;
  assign err_ovf       = err_ovf_r;
  assign err_div0      = err_div0_r;

endmodule
